// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Single-outstanding load/store sequencer between a core and a simple
// strobe/ack memory. A request is accepted in IDLE, presented to memory in
// ACCESS until mem_ack or a timeout, and reported by a one-cycle pulse in DONE.
//
// Parameters:
//   TIMEOUT    - max ACCESS cycles spent waiting for mem_ack (1..255)
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   req_valid  - core presents a request
//   req_we     - 1 = store, 0 = load
//   req_addr   - word address
//   req_wdata  - store data
//   req_ready  - unit can accept a request (IDLE only)
//   mem_req    - memory access strobe (ACCESS only)
//   mem_we     - memory write enable (never high without mem_req)
//   mem_addr   - memory address (latched request address)
//   mem_wdata  - memory write data (latched request data)
//   mem_ack    - memory completion, read data valid in the same cycle
//   mem_rdata  - memory read data
//   load_data  - registered load result
//   load_valid - one-cycle pulse: load_data updated by a completed load
//   store_done - one-cycle pulse: store completed
//   err        - one-cycle pulse: access timed out
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] load_data,
    output logic        load_valid,
    output logic        store_done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last wait cycle index; the counter starts at 0 in the first ACCESS cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,      state_d;
    logic        we_q,         we_d;
    logic [15:0] addr_q,       addr_d;
    logic [15:0] wdata_q,      wdata_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic [15:0] load_data_q,  load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        store_done_q, store_done_d;
    logic        err_q,        err_d;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        store_done_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ack is deliberately not looked at here
                if (req_valid) begin
                    state_d = ACCESS;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 8'd0;
                end
            end
            ACCESS: begin
                // An ack in the last allowed cycle beats the timeout.
                if (mem_ack) begin
                    state_d = DONE;
                    if (we_q) begin
                        store_done_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b1;
                        load_data_d  = mem_rdata;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        load_data_d = 16'hFFFF;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            cnt_q        <= 8'd0;
            load_data_q  <= 16'h0000;
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            store_done_q <= store_done_d;
            err_q        <= err_d;
        end
    end

    // Everything below is decoded from registered state only.
    assign req_ready  = (state_q == IDLE);
    assign mem_req    = (state_q == ACCESS);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign store_done = store_done_q;
    assign err        = err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, default 8, max ACCESS cycles waited for mem_ack (legal range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  16  word address.
REQ-007 req_wdata  input  16  store data.
REQ-008 req_ready  output  1  unit can accept a request.
REQ-009 mem_req  output  1  memory access strobe.
REQ-010 mem_we  output  1  memory write enable.
REQ-011 mem_addr  output  16  memory address.
REQ-012 mem_wdata  output  16  memory write data.
REQ-013 mem_ack  input  1  memory completion; read data valid in the same cycle.
REQ-014 mem_rdata  input  16  memory read data.
REQ-015 load_data  output  16  registered load result, the mem_data source for the execution unit.
REQ-016 load_valid  output  1  one-cycle pulse: load_data updated.
REQ-017 store_done  output  1  one-cycle pulse: store completed.
REQ-018 err  output  1  one-cycle pulse: access timed out.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-021 On acceptance, the unit SHALL latch req_we, req_addr and req_wdata, clear the timeout counter, and go to ACCESS.
REQ-022 In ACCESS, mem_req SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL show the latched values, held stable until exit.
REQ-023 In ACCESS, mem_ack=1 SHALL cause transition to DONE; for a load, load_data SHALL capture mem_rdata at that edge.
REQ-024 Each ACCESS cycle without mem_ack SHALL increment an 8-bit counter; when the counter reaches TIMEOUT-1 with mem_ack=0, the unit SHALL go to DONE with error flagged.
REQ-025 If mem_ack=1 arrives in the same cycle the timeout would fire, the ack SHALL win: no error, normal completion.
REQ-026 On a load timeout, load_data SHALL be set to 16'hFFFF.
REQ-027 DONE SHALL last exactly one cycle, then return to IDLE, with these pulses:
  - err=1 on a timeout;
  - otherwise load_valid=1 for a load, or store_done=1 for a store;
  - only one pulse per transaction.
REQ-028 mem_req SHALL be 0 in IDLE and DONE; mem_we SHALL be 0 whenever mem_req=0.
REQ-029 Latency: acceptance edge -> mem_req high next cycle; ack edge -> completion pulse in the following cycle; minimum request-to-request spacing is 3 cycles.
REQ-030 mem_ack while in IDLE or DONE SHALL be ignored (no state or data change).
REQ-031 load_data SHALL hold its value until the next load completion or timeout; stores SHALL NOT change it.
REQ-032 req_valid during ACCESS/DONE SHALL be ignored, with no queuing; the requester holds it until req_ready.

Reset
REQ-033 With rst=1 at a rising edge, the unit SHALL enter IDLE and set:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - load_data=0, load_valid=0, store_done=0, err=0;
  - counter=0.
REQ-034 Reset during ACCESS or DONE SHALL abort the transaction: no completion pulse; mem_req low from the edge after reset is sampled.
REQ-035 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-036 Load, ack after 2 wait cycles:
  - Stimulus: req addr 16'h0010, we=0; mem_rdata 16'hBEEF with ack on 3rd ACCESS cycle.
  - Required: load_data=16'hBEEF, load_valid pulses once, mem_req high exactly 3 cycles.
REQ-037 Store, zero-wait ack:
  - Stimulus: addr 16'h0020, wdata 16'h1234; ack in 1st ACCESS cycle.
  - Required: mem_we=1, mem_wdata=16'h1234 for 1 cycle, store_done pulses once, load_data unchanged.
REQ-038 Timeout, TIMEOUT=8, no ack:
  - Required: mem_req high 8 cycles, err pulses once, load_data=16'hFFFF, then req_ready=1.
REQ-039 Ack on the timeout cycle:
  - Stimulus: ack in 8th ACCESS cycle with rdata 16'h00A5.
  - Required: load_valid=1, err=0, load_data=16'h00A5.
REQ-040 Reset mid-ACCESS:
  - Stimulus: rst asserted on 2nd ACCESS cycle.
  - Required: next cycle mem_req=0, req_ready=1, all outputs 0, no pulses.
REQ-041 Back-to-back requests:
  - Stimulus: req_valid held high with a load then a store.
  - Required: second acceptance only in IDLE; stray ack in IDLE causes no change.
